// File: rtl/fir_response_capture.sv
// Captures the FIR response after an arm pulse: waits for the first non-zero sample,
// stores N_SAMPLES valid samples and keeps a running sum, peak magnitude and peak index.
module fir_response_capture #(
    parameter int NB_DATA = 8,
    parameter int NB_ADDR = 4,
    parameter int NB_SUM  = NB_DATA + NB_ADDR
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_arm,
    input  logic [NB_ADDR-1:0] i_rd_addr,
    output logic [NB_DATA-1:0] o_rd_data,
    output logic               o_busy,
    output logic               o_done,
    output logic [NB_SUM-1:0]  o_sum,
    output logic [NB_DATA-1:0] o_peak,
    output logic [NB_ADDR-1:0] o_peak_idx
);

    localparam int N_SAMPLES = 2 ** NB_ADDR;
    localparam logic [NB_ADDR-1:0] LAST_IDX = NB_ADDR'(N_SAMPLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NB_ADDR-1:0] count_q, count_d;
    logic [NB_SUM-1:0]  sum_q, sum_d;
    logic [NB_DATA-1:0] peak_q, peak_d;
    logic [NB_ADDR-1:0] peak_idx_q, peak_idx_d;
    logic [NB_DATA-1:0] rd_data_q;
    logic               wr_en;
    logic [NB_DATA-1:0] sample_abs;
    logic [NB_SUM-1:0]  sample_ext;

    logic [NB_DATA-1:0] mem_q [N_SAMPLES];

    // Unsigned magnitude: the most negative code maps to 2**(NB_DATA-1) without overflow.
    assign sample_abs = i_data[NB_DATA-1] ? ((~i_data) + {{(NB_DATA-1){1'b0}}, 1'b1}) : i_data;
    assign sample_ext = NB_SUM'($signed(i_data));

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        sum_d      = sum_q;
        peak_d     = peak_q;
        peak_idx_d = peak_idx_q;
        wr_en      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_arm) begin
                    state_d    = ST_ARMED;
                    count_d    = '0;
                    sum_d      = '0;
                    peak_d     = '0;
                    peak_idx_d = '0;
                end
            end
            ST_ARMED: begin
                if (i_valid && (i_data != '0)) begin
                    wr_en   = 1'b1;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (i_valid) begin
                    wr_en = 1'b1;
                    if (count_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Strict compare keeps the earliest index on ties.
        if (wr_en) begin
            count_d = count_q + {{(NB_ADDR-1){1'b0}}, 1'b1};
            sum_d   = sum_q + sample_ext;
            if (sample_abs > peak_q) begin
                peak_d     = sample_abs;
                peak_idx_d = count_q;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            sum_q      <= '0;
            peak_q     <= '0;
            peak_idx_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            sum_q      <= sum_d;
            peak_q     <= peak_d;
            peak_idx_q <= peak_idx_d;
            rd_data_q  <= mem_q[i_rd_addr];
        end
    end

    // Buffer storage carries no reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[count_q] <= i_data;
        end
    end

    assign o_busy     = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    assign o_done     = (state_q == ST_DONE);
    assign o_sum      = sum_q;
    assign o_peak     = peak_q;
    assign o_peak_idx = peak_idx_q;
    assign o_rd_data  = rd_data_q;

endmodule

// File: tb/tb_fir_response_capture.sv
// Randomized and directed capture runs; expected results are queued by the stimulus
// and checked by an independent monitor when the DUT reports done or returns read data.
module tb_fir_response_capture;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [7:0]  data;
    logic        arm;
    logic [3:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        busy;
    logic        done;
    logic [11:0] sum;
    logic [7:0]  peak;
    logic [3:0]  peak_idx;

    fir_response_capture #(.NB_DATA(8), .NB_ADDR(4), .NB_SUM(12)) dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_valid    (valid),
        .i_data     (data),
        .i_arm      (arm),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_data),
        .o_busy     (busy),
        .o_done     (done),
        .o_sum      (sum),
        .o_peak     (peak),
        .o_peak_idx (peak_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int         exp_sum_q[$];
    int         exp_peak_q[$];
    int         exp_idx_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] exp_buf [16];

    logic rd_chk;
    logic rd_chk_d;
    logic done_prev;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_chk_d <= rd_chk;

    // Monitor: results on each rising o_done, read data one cycle after each address.
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (exp_sum_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                check("sum", int'($signed(sum)), exp_sum_q.pop_front());
                check("peak", int'(peak), exp_peak_q.pop_front());
                check("peak_idx", int'(peak_idx), exp_idx_q.pop_front());
                $display("capture result: sum=%0d peak=%0d idx=%0d", $signed(sum), peak, peak_idx);
            end
        end
        done_prev <= done;
        if (rd_chk_d) begin
            if (exp_rd_q.size() == 0) check("rd_underflow", 1, 0);
            else check("rd_data", int'(rd_data), int'(exp_rd_q.pop_front()));
        end
    end

    function automatic int sample_for(input int kind, input int n);
        case (kind)
            1: return (n == 2) ? 3 : ((n == 3) ? 1 : 0);
            2: return (n == 0) ? -128 : ((n == 1) ? 127 : ((n == 2) ? -1 : 0));
            3: return -128;
            4: return (n == 0) ? 2 : ((n == 1) ? -5 : ((n == 2) ? 5 : 0));
            default: return ($urandom % 3 == 0) ? 0 : (int'($urandom % 256) - 128);
        endcase
    endfunction

    // kind 0 random; 1 impulse; 2 extremes; 3 all -128; 4 ties with i_valid toggling.
    task automatic run_capture(input int kind);
        int cap[16];
        int got, n, cyc, v, d, s, mx, idx;
        bit started;
        @(posedge clk); #1;
        arm = 1'b1;
        valid = 1'($urandom % 2);
        data = 8'h55;
        @(posedge clk); #1;
        arm = 1'b0;
        check("arm_done_low", int'(done), 0);
        check("arm_busy_high", int'(busy), 1);
        check("arm_sum_clear", int'(sum), 0);
        got = 0; n = 0; cyc = 0; started = 1'b0;
        while (got < 16 && cyc < 2000) begin
            if (kind == 4) v = (cyc % 2 == 0) ? 1 : 0;
            else if (kind == 0) v = ($urandom % 4 != 0) ? 1 : 0;
            else v = 1;
            if (v != 0) begin
                d = sample_for(kind, n);
                n++;
            end else begin
                d = int'($urandom % 256) - 128;
            end
            valid = v[0];
            data  = d[7:0];
            arm   = (kind == 0) && ($urandom % 10 == 0);
            if (v != 0 && (started || d != 0)) begin
                started  = 1'b1;
                cap[got] = d;
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        valid = 1'b0;
        arm   = 1'b0;
        if (got < 16) begin
            check("stim_bound", got, 16);
            return;
        end
        s = 0; mx = 0; idx = 0;
        foreach (cap[i]) begin
            s += cap[i];
            if ((cap[i] < 0 ? -cap[i] : cap[i]) > mx) mx = (cap[i] < 0 ? -cap[i] : cap[i]);
        end
        for (int i = 15; i >= 0; i--) begin
            if ((cap[i] < 0 ? -cap[i] : cap[i]) == mx) idx = i;
        end
        foreach (cap[i]) exp_buf[i] = cap[i][7:0];
        exp_sum_q.push_back(s);
        exp_peak_q.push_back(mx);
        exp_idx_q.push_back(idx);
        $display("capture kind=%0d issued: exp sum=%0d peak=%0d idx=%0d cycles=%0d", kind, s, mx, idx, cyc);
        for (int k = 0; k < 5 && !done; k++) begin
            @(posedge clk); #1;
        end
        if (!done) begin
            check("done_timeout", 0, 1);
            void'(exp_sum_q.pop_front());
            void'(exp_peak_q.pop_front());
            void'(exp_idx_q.pop_front());
        end
        @(posedge clk); #1;
    endtask

    task automatic readback();
        for (int a = 0; a < 16; a++) begin
            rd_addr = a[3:0];
            rd_chk  = 1'b1;
            exp_rd_q.push_back(exp_buf[a]);
            @(posedge clk); #1;
        end
        rd_chk = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic reset_midcapture();
        @(posedge clk); #1;
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1;
            data  = 8'(i + 7);
            @(posedge clk); #1;
        end
        check("pre_reset_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_done", int'(done), 0);
        check("async_rst_sum", int'(sum), 0);
        check("async_rst_peak", int'(peak), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1;
            data  = 8'h21;
            @(posedge clk); #1;
        end
        valid = 1'b0;
        check("idle_after_reset_busy", int'(busy), 0);
        check("idle_after_reset_sum", int'(sum), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        valid     = 1'b0;
        data      = '0;
        arm       = 1'b0;
        rd_addr   = '0;
        rd_chk    = 1'b0;
        rd_chk_d  = 1'b0;
        done_prev = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_sum", int'(sum), 0);
        check("reset_peak", int'(peak), 0);
        check("reset_idx", int'(peak_idx), 0);
        check("reset_rd_data", int'(rd_data), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_capture(1);
        readback();
        run_capture(2);
        readback();
        run_capture(3);
        run_capture(4);
        readback();
        reset_midcapture();
        for (int r = 0; r < 8; r++) begin
            run_capture(0);
            readback();
        end

        repeat (4) @(posedge clk);
        #1;
        check("pending_results", exp_sum_q.size(), 0);
        check("pending_reads", exp_rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
